cam_lookup: RTL and testbench
=============================

# cam_lookup

Sequential key-to-address lookup engine over a write-addressed content store with per-entry valid bits. The host loads or invalidates entries by address. Each key search is accepted over a valid/ready handshake, scanned one entry per clock, and answered with a hit flag and the lowest matching address. It is the read/search end paired with the team's CAM write path, and trades parallel comparators for single-comparator area.

## Interface
- WIDTH, 8, key/data width in bits
- DEPTH, 16, number of entries (power of two, ≥2)
- ADDR_W, 4, address width; must equal log2(DEPTH)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  entry write strobe
- wr_clr  input  1  qualifies wr_en; 1 = invalidate entry, 0 = load entry
- wr_addr  input  ADDR_W  target entry
- wr_data  input  WIDTH  data loaded when wr_en=1 and wr_clr=0
- req_valid  input  1  search request valid
- req_ready  output  1  engine can accept a request
- req_key  input  WIDTH  search key, sampled on accept
- req_mask  input  WIDTH  don't-care bits, sampled on accept; present only with CAM_LOOKUP_MASK_EN
- resp_valid  output  1  result valid
- resp_ready  input  1  consumer accepts result
- resp_hit  output  1  1 = match found
- resp_addr  output  ADDR_W  lowest matching index; 0 on miss

## Operation
- Storage: DEPTH × WIDTH data array plus DEPTH valid bits.
- Write path: when wr_en=1 and wr_clr=0, data[wr_addr] is set to wr_data and valid[wr_addr] is set to 1. When wr_en=1 and wr_clr=1, valid[wr_addr] is cleared and data is left unchanged.
- Writes are accepted in every state; they are independent of the search FSM.
- FSM states: IDLE, SCAN, RESP.
- IDLE: req_ready=1. When req_valid=1, the engine latches the key (and mask), sets idx=0 and moves to SCAN.
- SCAN: each cycle it compares entry idx.
  - Match condition: valid[idx] && data[idx]==key.
  - On a match, it registers hit=1, addr=idx and moves to RESP.
  - On no match with idx==DEPTH-1, it registers hit=0, addr=0 and moves to RESP.
  - Otherwise idx increments.
- RESP: resp_valid=1, and resp_hit/resp_addr are held stable. When resp_ready=1, the engine returns to IDLE.
- Multiple matches: the lowest index wins, by scan order.
- Invalid entries never match, including all-zero data against an all-zero key.
- idx is ADDR_W wide; the DEPTH-1 test terminates the scan, so idx never wraps.

## Timing
- Reset values: req_ready=0 during reset and 1 on the first cycle after it; resp_valid=0, resp_hit=0, resp_addr=0; all valid bits cleared; data cleared to 0; state IDLE.
- Let the accept edge be E0. A hit at index k gives resp_valid=1 from edge E(k+1). A miss gives resp_valid=1 from edge E(DEPTH).
- Throughput is one request per scan + 1 RESP cycle + 1 IDLE cycle. req_ready is 0 in SCAN and RESP, with no pipelining.
- A write to the entry being compared in the same cycle is not seen: the compare uses the pre-edge contents.
- Writes to entries with index below idx do not affect the in-flight search. Writes to entries with index above idx are seen when those entries are scanned.
- If resp_ready=1 on the first RESP cycle, resp_valid lasts exactly one cycle. resp_valid is never dropped before resp_ready.
- req_valid during SCAN or RESP is ignored and is not latched.
- A reset asserted in any state aborts the search without producing a response. The outputs return to their reset values on the next edge.

## Configuration
- CAM_LOOKUP_MASK_EN defined:
  - The req_mask port exists and is latched on accept.
  - Match condition: valid[idx] && ((data[idx] ^ key) & ~mask)==0.
  - mask = all ones matches any valid entry.
- CAM_LOOKUP_MASK_EN undefined:
  - The req_mask port is absent.
  - Matching is exact, over all WIDTH bits.

## Test plan
- Reset, then load addr 3 = 0xA5 and addr 9 = 0xA5, then search 0xA5 → resp_hit=1, resp_addr=3, resp_valid from E4.
- After reset, with no writes, search 0x00 → resp_hit=0, resp_addr=0, resp_valid from E16, i.e. the invalid zero entries do not match.
- Load addr 5 = 0x3C, invalidate addr 5 (wr_clr=1), search 0x3C → miss. Reload addr 5 = 0x3C, search again → hit at 5.
- Start a search for 0x77 on an empty CAM; write addr 12 = 0x77 while idx=2 → hit, addr 12. Repeat with the write at addr 1 while idx=2 → miss.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid, resp_hit and resp_addr stay stable, and req_ready stays 0 throughout. Then resp_ready=1 → IDLE with req_ready=1 on the next cycle.
- With CAM_LOOKUP_MASK_EN: load addr 2 = 0xF0, search key 0xFF with mask 0x0F → hit at 2. Without the macro, search key 0xFF → miss. In either build, asserting rst mid-SCAN yields no resp_valid and clears all entries.

Source files
------------

// File: rtl/cam_lookup.sv
// cam_lookup: sequential key-to-address lookup over a write-addressed
// content store with per-entry valid bits. A single comparator walks the
// entries one per clock and reports the lowest matching address.
// Optional feature macro: CAM_LOOKUP_MASK_EN adds a per-request don't-care
// mask (req_mask); without it, matching is exact over all WIDTH bits.
module cam_lookup #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_clr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WIDTH-1:0]  req_key,
`ifdef CAM_LOOKUP_MASK_EN
    input  logic [WIDTH-1:0]  req_mask,
`endif
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_hit,
    output logic [ADDR_W-1:0] resp_addr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_RESP
    } state_t;

    state_t             state_reg;
    logic [ADDR_W-1:0]  idx_reg;
    logic [WIDTH-1:0]   key_reg;
    logic               req_ready_reg;
    logic               resp_valid_reg;
    logic               resp_hit_reg;
    logic [ADDR_W-1:0]  resp_addr_reg;

    logic [WIDTH-1:0]   entry_data [DEPTH];
    logic [DEPTH-1:0]   entry_valid;
    logic [WIDTH-1:0]   cur_data;
    logic               cur_match;

    // Storage: each entry owns its data and valid register; writes are
    // independent of the search FSM. Reset clears data as well as valid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] data_reg;
            logic             valid_reg;

            // Load or invalidate this entry when addressed
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    if (wr_clr) begin
                        valid_reg <= 1'b0;
                    end else begin
                        data_reg  <= wr_data;
                        valid_reg <= 1'b1;
                    end
                end
            end

            assign entry_data[gi]  = data_reg;
            assign entry_valid[gi] = valid_reg;
        end
    endgenerate

    // The compare reads pre-edge contents, so a write landing on the entry
    // currently under test is not seen by this scan step.
    assign cur_data = entry_data[idx_reg];

`ifdef CAM_LOOKUP_MASK_EN
    logic [WIDTH-1:0] mask_reg;
    assign cur_match = entry_valid[idx_reg] &&
                       (((cur_data ^ key_reg) & ~mask_reg) == '0);
`else
    assign cur_match = entry_valid[idx_reg] && (cur_data == key_reg);
`endif

    // Search FSM: accept, scan one entry per clock, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            key_reg        <= '0;
            req_ready_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_hit_reg   <= 1'b0;
            resp_addr_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        key_reg       <= req_key;
                        idx_reg       <= '0;
                        req_ready_reg <= 1'b0;
                        state_reg     <= ST_SCAN;
                    end else begin
                        req_ready_reg <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (cur_match) begin
                        resp_hit_reg   <= 1'b1;
                        resp_addr_reg  <= idx_reg;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= ST_RESP;
                    end else if (idx_reg == ADDR_W'(DEPTH - 1)) begin
                        resp_hit_reg   <= 1'b0;
                        resp_addr_reg  <= '0;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= ST_RESP;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CAM_LOOKUP_MASK_EN
    // Mask is captured alongside the key on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_reg <= '0;
        end else if (state_reg == ST_IDLE && req_valid && req_ready_reg) begin
            mask_reg <= req_mask;
        end
    end
`endif

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_hit   = resp_hit_reg;
    assign resp_addr  = resp_addr_reg;

endmodule

// File: tb/tb_cam_lookup.sv
// tb_cam_lookup: scoreboard bench for cam_lookup. Expected responses
// (hit, address, latency from accept edge) are queued when a search is
// issued and compared when resp_valid appears. Works in both builds
// (with or without CAM_LOOKUP_MASK_EN).
module tb_cam_lookup;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic              wr_clr;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              req_valid;
    logic              req_ready;
    logic [WIDTH-1:0]  req_key;
`ifdef CAM_LOOKUP_MASK_EN
    logic [WIDTH-1:0]  req_mask;
`endif
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_hit;
    logic [ADDR_W-1:0] resp_addr;

    typedef struct {
        logic              hit;
        logic [ADDR_W-1:0] addr;
        int                lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    cam_lookup #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_clr     (wr_clr),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_key    (req_key),
`ifdef CAM_LOOKUP_MASK_EN
        .req_mask   (req_mask),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hit   (resp_hit),
        .resp_addr  (resp_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_addr", resp_addr, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_req_ready", req_ready, 1);
        $display("[TB] reset done");
    endtask

    task automatic write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d, input logic clr);
        wr_en   = 1'b1;
        wr_clr  = clr;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        wr_clr  = 1'b0;
        $display("[TB] write addr=%0d data=%02h clr=%0b", a, d, clr);
    endtask

    // Issue one search; optionally write (wa,wd) during the cycle where idx==wr_cycle;
    // hold resp_ready low for 'hold' RESP cycles before taking the result.
    task automatic search(input logic [WIDTH-1:0] key, input logic [WIDTH-1:0] mask,
                          input logic exp_hit, input logic [ADDR_W-1:0] exp_addr,
                          input int hold, input int wr_cycle,
                          input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd);
        exp_t e;
        exp_t r;
        int   lat;
        bit   got;
        bit   rdy;
        logic              h_hit;
        logic [ADDR_W-1:0] h_addr;
        e.hit  = exp_hit;
        e.addr = exp_hit ? exp_addr : '0;
        e.lat  = exp_hit ? int'(exp_addr) + 1 : DEPTH;
        sb_q.push_back(e);

        req_valid = 1'b1;
        req_key   = key;
`ifdef CAM_LOOKUP_MASK_EN
        req_mask  = mask;
`else
        if (mask != '0) $display("[TB] mask %02h ignored in exact-match build", mask);
`endif
        rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (req_ready) begin
                rdy = 1'b1;
                break;
            end
            tick();
        end
        if (!rdy) chk("req_ready_timeout", 0, 1);
        tick();                       // accept edge E0
        req_valid = 1'b0;
        chk("req_ready_busy", req_ready, 0);

        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n - 1 == wr_cycle) begin
                wr_en   = 1'b1;
                wr_clr  = 1'b0;
                wr_addr = wa;
                wr_data = wd;
            end
            tick();
            wr_en = 1'b0;
            if (resp_valid) begin
                lat = n;
                got = 1'b1;
                break;
            end
        end

        r = sb_q.pop_front();
        if (!got) begin
            chk("resp_timeout", 0, 1);
        end else begin
            chk("resp_hit", resp_hit, r.hit);
            chk("resp_addr", resp_addr, r.addr);
            chk("resp_latency", lat, r.lat);
        end
        $display("[TB] search key=%02h hit=%0b addr=%0d lat=%0d (exp hit=%0b addr=%0d lat=%0d)",
                 key, resp_hit, resp_addr, lat, r.hit, r.addr, r.lat);

        h_hit  = resp_hit;
        h_addr = resp_addr;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", resp_valid, 1);
            chk("hold_hit", resp_hit, h_hit);
            chk("hold_addr", resp_addr, h_addr);
            chk("hold_req_ready", req_ready, 0);
        end

        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("resp_drop", resp_valid, 0);
        chk("idle_req_ready", req_ready, 1);
    endtask

    initial begin
        bit seen;
        logic exp_m;
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_clr     = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        req_valid  = 1'b0;
        req_key    = '0;
`ifdef CAM_LOOKUP_MASK_EN
        req_mask   = '0;
`endif
        resp_ready = 1'b0;

        do_reset();

        // Empty CAM: invalid all-zero entries must not match a zero key
        search(8'h00, 8'h00, 1'b0, 4'd0, 0, -1, 4'd0, 8'h00);

        // Duplicate keys: lowest index wins; hold the response for 5 cycles
        write(4'd3, 8'hA5, 1'b0);
        write(4'd9, 8'hA5, 1'b0);
        search(8'hA5, 8'h00, 1'b1, 4'd3, 5, -1, 4'd0, 8'h00);

        // Invalidate then reload
        write(4'd5, 8'h3C, 1'b0);
        write(4'd5, 8'h00, 1'b1);
        search(8'h3C, 8'h00, 1'b0, 4'd0, 0, -1, 4'd0, 8'h00);
        write(4'd5, 8'h3C, 1'b0);
        search(8'h3C, 8'h00, 1'b1, 4'd5, 0, -1, 4'd0, 8'h00);

        // Writes during a scan: ahead of idx are seen, behind idx are not
        do_reset();
        search(8'h77, 8'h00, 1'b1, 4'd12, 0, 2, 4'd12, 8'h77);
        write(4'd12, 8'h00, 1'b1);
        search(8'h77, 8'h00, 1'b0, 4'd0, 0, 2, 4'd1, 8'h77);

        // Masked compare (exact-match build must miss)
        write(4'd2, 8'hF0, 1'b0);
`ifdef CAM_LOOKUP_MASK_EN
        exp_m = 1'b1;
`else
        exp_m = 1'b0;
`endif
        search(8'hFF, 8'h0F, exp_m, 4'd2, 0, -1, 4'd0, 8'h00);

        // Reset mid-scan: no response, entries cleared
        req_valid = 1'b1;
        req_key   = 8'hF0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_req_ready", req_ready, 0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) seen = 1'b1;
            tick();
        end
        chk("abort_no_resp", seen, 0);
        chk("abort_idle_ready", req_ready, 1);
        $display("[TB] reset mid-scan abort");
        search(8'hF0, 8'h00, 1'b0, 4'd0, 0, -1, 4'd0, 8'h00);
        search(8'hA5, 8'h00, 1'b0, 4'd0, 0, -1, 4'd0, 8'h00);

        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
